muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit with architectural HI/LO registers (MULT, MULTU, DIV, DIVU, MTHI, MTLO).

---
 rtl/muldiv_unit_if.sv | 37 +++
 rtl/muldiv_unit.sv | 236 +++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
//  Interface : muldiv_unit_if
//  Purpose   : Request/result bundle between the execute stage and the
//              iterative multiply/divide unit.
//  Signals   : a, b   - srcA / srcB operands
//              op     - operation select (MULT, MULTU, DIV, DIVU, MTHI, MTLO)
//              start  - request, only honoured while the unit is idle
//              busy   - operation in flight (controller stalls the PC)
//              done   - one-cycle pulse when HI/LO take a MUL/DIV result
//              hi, lo - architectural HI/LO registers
//  Modports  : master (execute stage / bench), slave (muldiv_unit)
//  Revision  : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             start;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output a, b, op, start,
    input  busy, done, hi, lo
  );

  modport slave (
    input  a, b, op, start,
    output busy, done, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module    : muldiv_unit
//  Purpose   : Iterative multiply/divide unit holding the architectural HI/LO
//              registers. MULT/MULTU use radix-2 shift-add, DIV/DIVU use
//              restoring division, one bit per clock over WIDTH iterations,
//              followed by a single sign-fixup cycle that writes HI/LO.
//              MTHI/MTLO write HI/LO directly when the unit is idle.
//  Ports     : clk   - rising-edge clock
//              reset - asynchronous active-low reset (0 = reset)
//              bus   - muldiv_unit_if.slave (a, b, op, start, busy, done,
//                      hi, lo)
//  Options   : MULDIV_FAST_MUL_EN - when defined, MULT/MULTU finish in the
//              start cycle on a full WIDTHxWIDTH multiplier; divide stays
//              iterative. Undefined: everything is iterative and no
//              hardware multiplier is inferred.
//  Revision  : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_unit_if.slave  bus
);

  localparam int                 c_cnt_w   = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(WIDTH - 1);
  localparam logic [2:0]         c_op_mult  = 3'b000;
  localparam logic [2:0]         c_op_multu = 3'b001;
  localparam logic [2:0]         c_op_div   = 3'b010;
  localparam logic [2:0]         c_op_divu  = 3'b011;
  localparam logic [2:0]         c_op_mthi  = 3'b100;
  localparam logic [2:0]         c_op_mtlo  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_is_div;
  logic                 r_neg_q;    // negate product / quotient at fixup
  logic                 r_neg_r;    // negate remainder at fixup
  logic                 r_bzero;    // divide by zero captured
  logic [WIDTH-1:0]     r_orig_a;   // signed dividend as captured
  logic [WIDTH-1:0]     r_opd;      // mul: |multiplicand|, div: |divisor|
  logic [2*WIDTH-1:0]   r_acc;      // mul: {partial, multiplier}; div: low half = dividend/quotient
  logic [WIDTH-1:0]     r_rem;      // div partial remainder (always < divisor)
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_done;

  // --------------------------------------------------------------------------
  // Request decode and operand conditioning
  // --------------------------------------------------------------------------
  logic             w_op_signed;
  logic             w_op_div;
  logic             w_launch;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;

  assign w_op_signed = (bus.op == c_op_mult) || (bus.op == c_op_div);
  assign w_op_div    = (bus.op == c_op_div)  || (bus.op == c_op_divu);

  // The most negative value maps onto itself, which read as unsigned is
  // exactly its magnitude, so no extra bit is needed.
  assign w_abs_a = (w_op_signed && bus.a[WIDTH-1]) ? (WIDTH'(0) - bus.a) : bus.a;
  assign w_abs_b = (w_op_signed && bus.b[WIDTH-1]) ? (WIDTH'(0) - bus.b) : bus.b;

`ifdef MULDIV_FAST_MUL_EN
  logic               w_fast;
  logic [2*WIDTH-1:0] w_fast_a;
  logic [2*WIDTH-1:0] w_fast_b;
  logic [2*WIDTH-1:0] w_fast_prod;

  assign w_launch = bus.start && w_op_div;
  assign w_fast   = bus.start && ((bus.op == c_op_mult) || (bus.op == c_op_multu));
  // Sign- or zero-extend to 2*WIDTH; the truncated 2*WIDTH product is then
  // correct for both signed and unsigned operands with one multiplier.
  assign w_fast_a    = {{WIDTH{w_op_signed & bus.a[WIDTH-1]}}, bus.a};
  assign w_fast_b    = {{WIDTH{w_op_signed & bus.b[WIDTH-1]}}, bus.b};
  assign w_fast_prod = w_fast_a * w_fast_b;
`else
  assign w_launch = bus.start && !bus.op[2];
`endif

  // --------------------------------------------------------------------------
  // Iteration datapath
  // --------------------------------------------------------------------------
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_nxt;
  logic [WIDTH:0]     w_div_sh;
  logic [WIDTH+1:0]   w_div_trial;
  logic               w_div_ok;

  // Shift-add: conditionally add the multiplicand into the upper half, then
  // shift the whole accumulator right, carry included.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + (r_acc[0] ? {1'b0, r_opd} : {(WIDTH+1){1'b0}});
  assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring divide: bring in the next dividend bit, trial-subtract the
  // divisor, keep the difference only when it did not borrow.
  assign w_div_sh    = {r_rem, r_acc[WIDTH-1]};
  assign w_div_trial = {1'b0, w_div_sh} - {2'b00, r_opd};
  assign w_div_ok    = !w_div_trial[WIDTH+1];

  // --------------------------------------------------------------------------
  // Sign fixup
  // --------------------------------------------------------------------------
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_prod_fix = r_neg_q ? ((2*WIDTH)'(0) - r_acc) : r_acc;
  assign w_quo_fix  = r_neg_q ? (WIDTH'(0) - r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_neg_r ? (WIDTH'(0) - r_rem) : r_rem;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_launch) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == c_last) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and HI/LO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_bzero  <= 1'b0;
      r_orig_a <= '0;
      r_opd    <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_cnt    <= '0;
            r_is_div <= w_op_div;
            r_neg_q  <= w_op_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_neg_r  <= w_op_signed && bus.a[WIDTH-1];
            r_bzero  <= (bus.b == '0);
            r_orig_a <= bus.a;
            r_rem    <= '0;
            if (w_op_div) begin
              r_opd <= w_abs_b;
              r_acc <= {{WIDTH{1'b0}}, w_abs_a};
            end else begin
              r_opd <= w_abs_a;
              r_acc <= {{WIDTH{1'b0}}, w_abs_b};
            end
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (w_fast) begin
            r_hi   <= w_fast_prod[2*WIDTH-1:WIDTH];
            r_lo   <= w_fast_prod[WIDTH-1:0];
            r_done <= 1'b1;
          end
`endif
          else if (bus.start && (bus.op == c_op_mthi)) begin
            r_hi <= bus.a;
          end else if (bus.start && (bus.op == c_op_mtlo)) begin
            r_lo <= bus.a;
          end
        end

        S_RUN: begin
          r_cnt <= r_cnt + c_cnt_w'(1);
          if (r_is_div) begin
            r_rem              <= w_div_ok ? w_div_trial[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
            r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], w_div_ok};
          end else begin
            r_acc <= w_mul_nxt;
          end
        end

        S_FIX: begin
          r_done <= 1'b1;
          if (r_is_div) begin
            if (r_bzero) begin
              r_hi <= r_orig_a;
              r_lo <= '1;
            end else begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
        end

        default: ;
      endcase
    end
  end

  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module    : tb_muldiv_unit
//  Purpose   : Self-checking bench for muldiv_unit. Directed vectors plus
//              randomized MUL/DIV traffic compared against an arithmetic
//              reference model; also MTHI/MTLO, no-ops, start-while-busy and
//              mid-operation reset. Honours MULDIV_FAST_MUL_EN.
//  Revision  : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] m_hi, m_lo;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, ehi, elo;
  } vec_t;

  // Reference: plain arithmetic on the architectural definition.
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = 64'd0;
    case (op)
      3'b000: res = 64'(sa * sb);
      3'b001: res = {32'd0, a} * {32'd0, b};
      3'b010: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
      end
      3'b011: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  function automatic int exp_lat(input logic [2:0] op);
    if (FAST && op[2:1] == 2'b00) return 0;
    return 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 3));
      3: return 32'($urandom_range(0, 200)) - 32'd100;
      default: return $urandom;
    endcase
  endfunction

  // Launch one op from "#1 after a posedge"; optionally inject another start
  // 5 cycles into the run. Returns at "#1 after" the cycle following done.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit inj, input logic [2:0] iop, input logic [31:0] ia,
                        output logic [31:0] ghi, output logic [31:0] glo, output int lat,
                        output logic busy0, output logic done_next, output logic busy_next);
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.op = 3'b111;
    busy0 = bus.busy;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (inj && lat == 5) begin bus.op = iop; bus.a = ia; bus.start = 1'b1; end
      else bus.start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    ghi = bus.hi; glo = bus.lo;
    @(posedge clk); #1;
    done_next = bus.done;
    busy_next = bus.busy;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.op = 3'b111; bus.a = '0; bus.b = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++; if (bus.hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
    total++; if (bus.lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
    reset = 1'b1;
    @(posedge clk); #1;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_directed();
    vec_t vt[8];
    logic [31:0] ghi, glo;
    int lat;
    logic b0, dn, bn;
    vt[0] = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vt[1] = '{3'b011, 32'd100,        32'd7,         32'd2,         32'd14};
    vt[2] = '{3'b010, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vt[3] = '{3'b010, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vt[4] = '{3'b010, 32'd5,          32'd0,         32'd5,         32'hFFFF_FFFF};
    vt[5] = '{3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1};
    vt[6] = '{3'b011, 32'hFFFF_FFF0,  32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF};
    vt[7] = '{3'b000, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'd0};
    for (int i = 0; i < 8; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, 1'b0, 3'b111, 32'd0, ghi, glo, lat, b0, dn, bn);
      total++; if (ghi !== vt[i].ehi) begin bad++; $display("FAIL dir%0d_hi got=%h exp=%h", i, ghi, vt[i].ehi); end
      total++; if (glo !== vt[i].elo) begin bad++; $display("FAIL dir%0d_lo got=%h exp=%h", i, glo, vt[i].elo); end
      total++; if (lat != exp_lat(vt[i].op)) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, exp_lat(vt[i].op)); end
      total++; if (b0 !== (exp_lat(vt[i].op) != 0)) begin bad++; $display("FAIL dir%0d_busy_after_start got=%b exp=%b", i, b0, exp_lat(vt[i].op) != 0); end
      total++; if (dn !== 1'b0 || bn !== 1'b0) begin bad++; $display("FAIL dir%0d_done_pulse got done=%b busy=%b exp 0/0", i, dn, bn); end
      m_hi = vt[i].ehi; m_lo = vt[i].elo;
    end
  endtask

  task automatic test_mthi_mtlo();
    bus.op = 3'b101; bus.a = 32'h0000_ABCD; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    total++; if (bus.lo !== 32'h0000_ABCD) begin bad++; $display("FAIL mtlo_lo got=%h exp=0000abcd", bus.lo); end
    total++; if (bus.hi !== m_hi) begin bad++; $display("FAIL mtlo_hi got=%h exp=%h", bus.hi, m_hi); end
    total++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL mtlo_flags got done=%b busy=%b exp 0/0", bus.done, bus.busy); end
    m_lo = 32'h0000_ABCD;
    bus.op = 3'b100; bus.a = 32'h5678_9ABC; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    total++; if (bus.hi !== 32'h5678_9ABC) begin bad++; $display("FAIL mthi_hi got=%h exp=56789abc", bus.hi); end
    total++; if (bus.lo !== m_lo) begin bad++; $display("FAIL mthi_lo got=%h exp=%h", bus.lo, m_lo); end
    total++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL mthi_flags got done=%b busy=%b exp 0/0", bus.done, bus.busy); end
    m_hi = 32'h5678_9ABC;
  endtask

  task automatic test_noop();
    for (int i = 6; i < 8; i++) begin
      bus.op = 3'(i); bus.a = $urandom; bus.b = $urandom; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      total++; if (bus.hi !== m_hi || bus.lo !== m_lo) begin bad++; $display("FAIL noop%0d_hilo got=%h/%h exp=%h/%h", i, bus.hi, bus.lo, m_hi, m_lo); end
      total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL noop%0d_flags got busy=%b done=%b exp 0/0", i, bus.busy, bus.done); end
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] ghi, glo;
    logic [63:0] e;
    int lat;
    logic b0, dn, bn;
    run_op(3'b010, 32'd1000, 32'd7, 1'b1, 3'b100, 32'h0000_1234, ghi, glo, lat, b0, dn, bn);
    e = ref_model(3'b010, 32'd1000, 32'd7);
    total++; if ({ghi, glo} !== e) begin bad++; $display("FAIL busy_mthi_result got=%h%h exp=%h", ghi, glo, e); end
    total++; if (lat != 33) begin bad++; $display("FAIL busy_mthi_latency got=%0d exp=33", lat); end
    run_op(3'b011, 32'hDEAD_BEEF, 32'd13, 1'b1, 3'b000, 32'd9, ghi, glo, lat, b0, dn, bn);
    e = ref_model(3'b011, 32'hDEAD_BEEF, 32'd13);
    total++; if ({ghi, glo} !== e) begin bad++; $display("FAIL busy_mult_result got=%h%h exp=%h", ghi, glo, e); end
    total++; if (bn !== 1'b0) begin bad++; $display("FAIL busy_mult_relaunch got busy=%b exp=0", bn); end
    m_hi = e[63:32]; m_lo = e[31:0];
  endtask

  task automatic test_reset_mid();
    logic [31:0] ghi, glo;
    int lat;
    logic b0, dn, bn;
    bus.op = 3'b000; bus.a = 32'h1234_5678; bus.b = 32'h0000_0F0F; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL midreset_flags got busy=%b done=%b exp 0/0", bus.busy, bus.done); end
    total++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin bad++; $display("FAIL midreset_hilo got=%h/%h exp=0/0", bus.hi, bus.lo); end
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midreset_idle got busy=%b exp=0", bus.busy); end
    run_op(3'b000, 32'd3, 32'd4, 1'b0, 3'b111, 32'd0, ghi, glo, lat, b0, dn, bn);
    total++; if (ghi !== 32'd0 || glo !== 32'd12) begin bad++; $display("FAIL midreset_mult got=%h/%h exp=0/c", ghi, glo); end
    m_hi = ghi; m_lo = glo;
  endtask

  task automatic test_random();
    logic [31:0] ghi, glo, a, b;
    logic [2:0] op;
    logic [63:0] e;
    int lat;
    logic b0, dn, bn;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 3));
      a = pick_operand();
      b = pick_operand();
      run_op(op, a, b, 1'b0, 3'b111, 32'd0, ghi, glo, lat, b0, dn, bn);
      e = ref_model(op, a, b);
      total++; if ({ghi, glo} !== e) begin bad++; $display("FAIL rand%0d op=%0d a=%h b=%h got=%h%h exp=%h", i, op, a, b, ghi, glo, e); end
      total++; if (lat != exp_lat(op)) begin bad++; $display("FAIL rand%0d_latency got=%0d exp=%0d", i, lat, exp_lat(op)); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mthi_mtlo();
    test_noop();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
